trigger_capture: RTL and testbench
==================================

Name: trigger_capture

Overview:
- Consumer of the level-trigger outputs: accepts the same 32-bit sample stream plus its four per-beat trigger flags, and records a pre/post-trigger window into an on-chip ring buffer.
- Once the window is complete, replays it on an AXI4-Stream master with tlast marking the final sample.
- Sits between the level trigger and the DMA/readout path of the scope acquisition chain.

Parameters:
- ADDR_WIDTH, 10, log2 of buffer depth (depth D = 2^ADDR_WIDTH samples)
- DATA_WIDTH, 32, sample width (two 16-bit channels, passed through unmodified)

Ports:
- stream_clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- s_tready  out  1  sample stream ready
- s_tvalid  in  1  sample stream valid
- s_tdata  in  DATA_WIDTH  sample data
- ch1_rising, ch1_falling, ch2_rising, ch2_falling  in  1 each  trigger flags, aligned with the s_tdata beat
- trig_mask  in  4  enables {ch2_falling, ch2_rising, ch1_falling, ch1_rising}, bit 0 = ch1_rising
- force_trigger  in  1  one-cycle software trigger pulse
- arm  in  1  one-cycle pulse that starts an acquisition
- pre_count  in  ADDR_WIDTH  samples kept before the trigger
- post_count  in  ADDR_WIDTH+1  samples from the trigger onward, including the trigger sample
- m_tready  in  1  readout ready
- m_tvalid  out  1  readout valid
- m_tdata  out  DATA_WIDTH  readout data
- m_tlast  out  1  last sample of the window
- busy  out  1  high in every state except IDLE
- triggered  out  1  trigger accepted, held until the next arm or reset
- done  out  1  one-cycle pulse after the last readout beat completes

Behaviour:
- s_tready is constant 1; the block never backpressures. Beats arriving outside FILL/ARMED/POST are dropped.
- Reset: state = IDLE, write pointer 0, all counters 0, m_tvalid = 0, m_tlast = 0, busy = 0, triggered = 0, done = 0. Reset mid-acquisition or mid-readout aborts immediately, with no further m_tvalid.
- pre_count and post_count are latched when arm is accepted. Window length L = pre_latched + post_latched.
  - If L > D or post_latched = 0: arm is ignored and the block stays in IDLE.
- arm is accepted only in IDLE. In any other state it is ignored.
- FSM:
  - IDLE -> FILL on an accepted arm.
  - FILL: each valid beat is written at wptr, wptr++ (wraps modulo D), fill count++. Triggers are ignored. When fill count = pre_latched -> ARMED. If pre_latched = 0, go directly to ARMED.
  - ARMED: each valid beat is written.
    - hit = s_tvalid & (|(trig_mask & flags)) | force_trigger.
    - force_trigger raised without s_tvalid is held pending and fires on the next valid beat.
    - On hit: that beat is stored, trig_addr = wptr, post count = 1, triggered <= 1. If post_latched = 1 -> READ, else -> POST.
  - POST: each valid beat is written and post count++. When post count reaches post_latched (the beat on which it becomes equal is written) -> READ.
  - READ: read address starts at (trig_addr - pre_latched) mod D and increments with wrap. Exactly L beats are emitted. The final beat has m_tlast = 1. After it is accepted: done pulses for 1 cycle -> IDLE.
- Buffer: single-port-write / single-port-read RAM with a 1-cycle read latency.
  - Readout uses a prefetch plus a 1-entry output register, so m_tvalid may stay high every cycle while m_tready = 1 (one beat per clock).
  - Before the first beat of READ, m_tvalid rises 2 cycles after entering READ.
  - m_tdata and m_tlast stay stable while m_tvalid & !m_tready.
- Simultaneous events in ARMED: multiple flags in one beat count as a single trigger. force_trigger and a flag together count as one trigger.
- Pointer arithmetic is modulo D. Samples older than D beats are overwritten; this is legal in ARMED while waiting for a trigger.

Test Plan:
- Reset mid-READ (after 3 of 8 beats) -> m_tvalid = 0 on the next cycle, busy = 0; a fresh arm then captures correctly.
- Ramp data 0,1,2,...; pre = 4, post = 4, mask = 0001; ch1_rising on the beat carrying 100 -> readout 96..103, tlast on 103, done pulse, triggered = 1.
- pre = 0, post = 1, force_trigger on the beat carrying 7 -> a single beat 7 with tlast = 1.
- ADDR_WIDTH = 4 (D = 16), pre = 10, post = 6; 40 beats pass in ARMED before a ch2_falling trigger at value 50 -> readout 40..55, wrapping across address 15->0.
- Readout with m_tready toggling 1,0,0,1,... -> no duplicated or lost samples; m_tdata held stable while stalled.
- pre = 10, post = 10 with D = 16 -> arm ignored, busy stays 0. A flag arriving with mask = 0 in ARMED -> no trigger.

Source files
------------

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_capture
//  Brief    : Records a pre/post-trigger sample window into a ring buffer and
//             replays it on an AXI4-Stream master with tlast on the final beat.
//  Revision : 1.0 - initial release
// ============================================================================
module trigger_capture #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  stream_clk,
    input  logic                  reset,
    output logic                  s_tready,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  ch1_rising,
    input  logic                  ch1_falling,
    input  logic                  ch2_rising,
    input  logic                  ch2_falling,
    input  logic [3:0]            trig_mask,
    input  logic                  force_trigger,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] pre_count,
    input  logic [ADDR_WIDTH:0]   post_count,
    input  logic                  m_tready,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    localparam int                    c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH+1:0] c_DEPTH_W  = (ADDR_WIDTH+2)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_POST_ONE = (ADDR_WIDTH+1)'(1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FILL  = 3'd1;
    localparam logic [2:0] c_ARMED = 3'd2;
    localparam logic [2:0] c_POST  = 3'd3;
    localparam logic [2:0] c_READ  = 3'd4;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic [ADDR_WIDTH-1:0] r_pre;
    logic [ADDR_WIDTH-1:0] r_fill_cnt;
    logic [ADDR_WIDTH:0]   r_post;
    logic [ADDR_WIDTH:0]   r_post_cnt;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issue_cnt;
    logic                  r_pending;
    logic                  r_triggered;
    logic                  r_done;
    logic                  r_q_valid;
    logic                  r_q_last;
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    logic [ADDR_WIDTH+1:0] w_len_full;
    logic                  w_arm_ok;
    logic                  w_flag_hit;
    logic                  w_hit;
    logic                  w_wr_en;
    logic                  w_out_ready;
    logic                  w_issue;
    logic                  w_last_accept;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_fill_next;
    logic [ADDR_WIDTH:0]   w_post_next;

    assign w_len_full    = {2'b00, pre_count} + {1'b0, post_count};
    assign w_arm_ok      = arm && (r_state == c_IDLE) && (post_count != '0) && (w_len_full <= c_DEPTH_W);
    assign w_flag_hit    = |(trig_mask & {ch2_falling, ch2_rising, ch1_falling, ch1_rising});
    assign w_hit         = (r_state == c_ARMED) && s_tvalid && (w_flag_hit || force_trigger || r_pending);
    assign w_wr_en       = s_tvalid && ((r_state == c_FILL) || (r_state == c_ARMED) || (r_state == c_POST));
    assign w_out_ready   = !r_m_tvalid || m_tready;
    // A new read may only be issued when the prefetch slot is empty or draining this cycle.
    assign w_issue       = (r_state == c_READ) && (r_issue_cnt != r_len) && (!r_q_valid || w_out_ready);
    assign w_last_accept = r_m_tvalid && m_tready && r_m_tlast;
    assign w_rd_addr     = r_trig_addr - r_pre + r_issue_cnt[ADDR_WIDTH-1:0];
    assign w_fill_next   = r_fill_cnt + 1'b1;
    assign w_post_next   = r_post_cnt + 1'b1;

    always_ff @(posedge stream_clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= s_tdata;
        end
        if (w_issue) begin
            r_ram_q <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge stream_clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_wptr      <= '0;
            r_trig_addr <= '0;
            r_pre       <= '0;
            r_fill_cnt  <= '0;
            r_post      <= '0;
            r_post_cnt  <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_pending   <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_q_valid   <= 1'b0;
            r_q_last    <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_m_tdata   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_arm_ok) begin
                        r_pre       <= pre_count;
                        r_post      <= post_count;
                        r_len       <= w_len_full[ADDR_WIDTH:0];
                        r_fill_cnt  <= '0;
                        r_post_cnt  <= '0;
                        r_issue_cnt <= '0;
                        r_pending   <= 1'b0;
                        r_triggered <= 1'b0;
                        r_state     <= (pre_count == '0) ? c_ARMED : c_FILL;
                    end
                end
                c_FILL: begin
                    if (s_tvalid) begin
                        r_fill_cnt <= w_fill_next;
                        if (w_fill_next == r_pre) begin
                            r_state <= c_ARMED;
                        end
                    end
                end
                c_ARMED: begin
                    if (w_hit) begin
                        r_trig_addr <= r_wptr;
                        r_post_cnt  <= c_POST_ONE;
                        r_triggered <= 1'b1;
                        r_pending   <= 1'b0;
                        r_state     <= (r_post == c_POST_ONE) ? c_READ : c_POST;
                    end else if (!s_tvalid && force_trigger) begin
                        r_pending <= 1'b1;
                    end
                end
                c_POST: begin
                    if (s_tvalid) begin
                        r_post_cnt <= w_post_next;
                        if (w_post_next == r_post) begin
                            r_state <= c_READ;
                        end
                    end
                end
                c_READ: begin
                    if (w_last_accept) begin
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (w_issue) begin
                r_q_valid   <= 1'b1;
                r_q_last    <= (r_issue_cnt == (r_len - 1'b1));
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end else if (r_q_valid && w_out_ready) begin
                r_q_valid <= 1'b0;
            end

            if (w_out_ready) begin
                r_m_tvalid <= r_q_valid;
                r_m_tlast  <= r_q_valid && r_q_last;
                if (r_q_valid) begin
                    r_m_tdata <= r_ram_q;
                end
            end
        end
    end

    assign s_tready  = 1'b1;
    assign m_tvalid  = r_m_tvalid;
    assign m_tdata   = r_m_tdata;
    assign m_tlast   = r_m_tlast;
    assign busy      = (r_state != c_IDLE);
    assign triggered = r_triggered;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trigger_capture
//  Brief    : Directed self-checking bench for trigger_capture (16-deep buffer).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          stream_clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_tready;
    logic          s_tvalid = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          ch1_rising = 1'b0, ch1_falling = 1'b0, ch2_rising = 1'b0, ch2_falling = 1'b0;
    logic [3:0]    trig_mask = '0;
    logic          force_trigger = 1'b0;
    logic          arm = 1'b0;
    logic [AW-1:0] pre_count = '0;
    logic [AW:0]   post_count = '0;
    logic          m_tready = 1'b1;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          busy;
    logic          triggered;
    logic          done;

    int n_pass  = 0;
    int n_total = 0;

    trigger_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .stream_clk   (stream_clk),
        .reset        (reset),
        .s_tready     (s_tready),
        .s_tvalid     (s_tvalid),
        .s_tdata      (s_tdata),
        .ch1_rising   (ch1_rising),
        .ch1_falling  (ch1_falling),
        .ch2_rising   (ch2_rising),
        .ch2_falling  (ch2_falling),
        .trig_mask    (trig_mask),
        .force_trigger(force_trigger),
        .arm          (arm),
        .pre_count    (pre_count),
        .post_count   (post_count),
        .m_tready     (m_tready),
        .m_tvalid     (m_tvalid),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done)
    );

    always #5 stream_clk = ~stream_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge stream_clk);
        #1;
    endtask

    task automatic do_arm(input int pre, input int post, input logic [3:0] mask);
        pre_count  = pre[AW-1:0];
        post_count = post[AW:0];
        trig_mask  = mask;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic beat(input int d, input logic [3:0] fl, input logic f);
        s_tvalid = 1'b1;
        s_tdata  = d;
        {ch2_falling, ch2_rising, ch1_falling, ch1_rising} = fl;
        force_trigger = f;
        tick();
        s_tvalid = 1'b0;
        {ch2_falling, ch2_rising, ch1_falling, ch1_rising} = 4'b0000;
        force_trigger = 1'b0;
    endtask

    // Drains n beats expecting base, base+1, ...; optional 1,0,0,1 ready pattern.
    task automatic collect(input string tag, input int n, input int base, input logic stall);
        int          got = 0;
        int          cyc = 0;
        logic        held_v = 1'b0;
        logic [31:0] held_d = '0;
        logic [3:0]  pat = 4'b1001;
        while (got < n && cyc < 300) begin
            if (held_v) begin
                check({tag, "_hold_valid"}, m_tvalid, 1);
                check({tag, "_hold_data"}, m_tdata, held_d);
            end
            m_tready = stall ? pat[cyc % 4] : 1'b1;
            held_v   = 1'b0;
            if (m_tvalid) begin
                if (m_tready) begin
                    check({tag, "_data"}, m_tdata, base + got);
                    check({tag, "_last"}, m_tlast, (got == n - 1));
                    got++;
                end else begin
                    held_v = 1'b1;
                    held_d = m_tdata;
                end
            end
            tick();
            cyc++;
        end
        check({tag, "_count"}, got, n);
        check({tag, "_done"}, done, 1);
        m_tready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int cyc;

        repeat (3) tick();
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("s_tready", s_tready, 1);
        reset = 1'b0;
        tick();

        // Ramp capture, ch1_rising at 100
        do_arm(4, 4, 4'b0001);
        check("ramp_busy", busy, 1);
        for (int v = 0; v <= 103; v++) beat(v, (v == 100) ? 4'b0001 : 4'b0000, 1'b0);
        check("ramp_lat0", m_tvalid, 0);
        tick();
        check("ramp_lat1", m_tvalid, 0);
        tick();
        check("ramp_lat2", m_tvalid, 1);
        check("ramp_triggered", triggered, 1);
        collect("ramp", 8, 96, 1'b0);
        tick();
        check("ramp_done_pulse", done, 0);
        check("ramp_idle", busy, 0);
        check("ramp_trig_held", triggered, 1);

        // pre=0, post=1, forced on beat 7
        do_arm(0, 1, 4'b0000);
        for (int v = 0; v <= 7; v++) beat(v, 4'b0000, (v == 7));
        collect("single", 1, 7, 1'b0);

        // Masked-off flags do not trigger; force without valid stays pending
        do_arm(2, 2, 4'b0000);
        check("mask_trig_clear", triggered, 0);
        for (int v = 200; v <= 209; v++) beat(v, 4'b1111, 1'b0);
        check("mask_no_trig", triggered, 0);
        check("mask_still_busy", busy, 1);
        force_trigger = 1'b1;
        tick();
        force_trigger = 1'b0;
        tick();
        check("pending_no_trig", triggered, 0);
        beat(210, 4'b0000, 1'b0);
        check("pending_fired", triggered, 1);
        beat(211, 4'b0000, 1'b0);
        collect("pending", 4, 208, 1'b1);

        // Full-depth window wrapping the buffer, ch2_falling at 50
        do_arm(10, 6, 4'b1000);
        for (int v = 0; v <= 55; v++)
            beat(v, (v == 50) ? 4'b1000 : ((v == 30) ? 4'b0001 : 4'b0000), 1'b0);
        collect("wrap", 16, 40, 1'b1);

        // Oversized window: arm ignored
        do_arm(10, 10, 4'b0001);
        check("oversize_busy", busy, 0);
        beat(1, 4'b0001, 1'b0);
        beat(2, 4'b0001, 1'b0);
        check("oversize_busy2", busy, 0);
        check("oversize_valid", m_tvalid, 0);

        // Reset mid-READ after 3 of 8 beats, then a fresh capture
        do_arm(4, 4, 4'b0001);
        for (int v = 300; v <= 313; v++) beat(v, (v == 310) ? 4'b0001 : 4'b0000, 1'b0);
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 50) begin
            if (m_tvalid) begin
                check("abort_data", m_tdata, 306 + got);
                got++;
            end
            tick();
            cyc++;
        end
        check("abort_count", got, 3);
        reset = 1'b1;
        tick();
        check("abort_valid", m_tvalid, 0);
        check("abort_busy", busy, 0);
        check("abort_triggered", triggered, 0);
        reset = 1'b0;
        tick();
        tick();
        check("abort_quiet", m_tvalid, 0);
        do_arm(1, 2, 4'b0000);
        beat(499, 4'b0000, 1'b0);
        beat(500, 4'b0000, 1'b1);
        beat(501, 4'b0000, 1'b0);
        collect("after_reset", 3, 499, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
